// File: rtl/leaf_stage_fifo_if.sv
// Valid/ready stream bundle between a producer, the leaf stage FIFO and the leaf consumer.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; the modports fix who drives which side.
interface leaf_stage_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;
    logic              almost_full;

    // Environment side: producer inputs, consumer ready, observes status.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full
    );

    // The FIFO stage itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full
    );
endinterface

// File: rtl/leaf_stage_fifo.sv
// Elastic first-word-fall-through buffer (DEPTH entries) in front of a leaf instance.
// Latency: 1 cycle in-to-out minimum, no same-cycle bypass.
// Backpressure: in_ready = not full from registered count; no path from out_ready. Optional stats: LEAF_FIFO_STATS_EN.
module leaf_stage_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
`ifdef LEAF_FIFO_STATS_EN
    output logic [15:0]        stat_push_cnt,
    output logic [15:0]        stat_full_cyc,
`endif
    leaf_stage_fifo_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              push;
    logic              pop;
    logic              out_valid;

    assign out_valid       = (count_q != '0);
    assign bus.in_ready    = (count_q != DEPTH_C);
    assign bus.out_valid   = out_valid;
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= AFULL_C);
    // When empty, show the last head word that was presented (0 after reset).
    assign bus.out_data    = out_valid ? mem_q[rd_ptr_q] : hold_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = out_valid & bus.out_ready;

    // Next-state for pointers, occupancy and the held output word; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = out_valid ? mem_q[rd_ptr_q] : hold_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage array has no reset; a flushed cycle must not write.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

`ifdef LEAF_FIFO_STATS_EN
    logic [15:0] push_cnt_q, push_cnt_d;
    logic [15:0] full_cyc_q, full_cyc_d;

    assign stat_push_cnt = push_cnt_q;
    assign stat_full_cyc = full_cyc_q;

    // Saturating event counters, cleared by flush.
    always_comb begin
        push_cnt_d = push_cnt_q;
        full_cyc_d = full_cyc_q;
        if (flush) begin
            push_cnt_d = '0;
            full_cyc_d = '0;
        end else begin
            if (push && push_cnt_q != 16'hFFFF)               push_cnt_d = push_cnt_q + 1'b1;
            if (count_q == DEPTH_C && full_cyc_q != 16'hFFFF) full_cyc_d = full_cyc_q + 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_q <= '0;
            full_cyc_q <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            full_cyc_q <= full_cyc_d;
        end
    end
`endif
endmodule

// File: tb/tb_leaf_stage_fifo.sv
// Directed bench for leaf_stage_fifo (DATA_W=32, DEPTH=8, AFULL_LVL=6).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Expected values are written by hand from the stage's defined behaviour.
module tb_leaf_stage_fifo;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
`ifdef LEAF_FIFO_STATS_EN
    logic [15:0] stat_push_cnt;
    logic [15:0] stat_full_cyc;
`endif

    int passed = 0;
    int total  = 0;

    leaf_stage_fifo_if #(.DATA_W(32), .DEPTH(8)) ifc ();

    leaf_stage_fifo #(.DATA_W(32), .DEPTH(8), .AFULL_LVL(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
`ifdef LEAF_FIFO_STATS_EN
        .stat_push_cnt (stat_push_cnt),
        .stat_full_cyc (stat_full_cyc),
`endif
        .bus           (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b0;

        // Reset, then idle for 10 cycles
        #2;
        chk("rst_out_data", ifc.out_data, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_in_ready", {31'b0, ifc.in_ready}, 32'd1);
            chk("idle_out_valid", {31'b0, ifc.out_valid}, 32'd0);
            chk("idle_count", {28'b0, ifc.count}, 32'd0);
            chk("idle_afull", {31'b0, ifc.almost_full}, 32'd0);
        end

        // Push 0x11,0x22,0x33 then drain in order
        ifc.in_valid = 1'b1;
        ifc.in_data  = 32'h11;
        step();
        chk("p1_count", {28'b0, ifc.count}, 32'd1);
        chk("p1_out_valid", {31'b0, ifc.out_valid}, 32'd1);
        chk("p1_out_data", ifc.out_data, 32'h11);
        ifc.in_data = 32'h22;
        step();
        chk("p2_count", {28'b0, ifc.count}, 32'd2);
        chk("p2_out_data", ifc.out_data, 32'h11);
        ifc.in_data = 32'h33;
        step();
        chk("p3_count", {28'b0, ifc.count}, 32'd3);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        chk("d_head0", ifc.out_data, 32'h11);
        step();
        chk("d_count2", {28'b0, ifc.count}, 32'd2);
        chk("d_head1", ifc.out_data, 32'h22);
        step();
        chk("d_count1", {28'b0, ifc.count}, 32'd1);
        chk("d_head2", ifc.out_data, 32'h33);
        step();
        chk("d_count0", {28'b0, ifc.count}, 32'd0);
        chk("d_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("d_hold_data", ifc.out_data, 32'h33);
        ifc.out_ready = 1'b0;

        // Fill to 8; almost_full from count 6; 9th word refused
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifc.in_data = 32'hA0 + i;
            step();
            chk("fill_count", {28'b0, ifc.count}, i + 1);
            chk("fill_afull", {31'b0, ifc.almost_full}, (i + 1 >= 6) ? 32'd1 : 32'd0);
        end
        chk("full_in_ready", {31'b0, ifc.in_ready}, 32'd0);
        ifc.in_data = 32'hEE;
        step();
        chk("full_refuse_count", {28'b0, ifc.count}, 32'd8);
        chk("full_head", ifc.out_data, 32'hA0);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        step();
        chk("pop_count", {28'b0, ifc.count}, 32'd7);
        chk("pop_in_ready", {31'b0, ifc.in_ready}, 32'd1);
`ifdef LEAF_FIFO_STATS_EN
        chk("stat_full_cyc", {16'b0, stat_full_cyc}, 32'd2);
        chk("stat_push_cnt", {16'b0, stat_push_cnt}, 32'd11);
`endif
        for (int i = 1; i < 8; i++) begin
            chk("fill_order", ifc.out_data, 32'hA0 + i);
            step();
        end
        chk("fill_drained", {28'b0, ifc.count}, 32'd0);
        ifc.out_ready = 1'b0;

        // Prime 3 words, then 20 cycles of simultaneous push/pop across pointer wrap
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifc.in_data = i;
            step();
        end
        chk("prime_count", {28'b0, ifc.count}, 32'd3);
        ifc.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ifc.in_data = k + 3;
            chk("stream_data", ifc.out_data, k);
            step();
            chk("stream_count", {28'b0, ifc.count}, 32'd3);
        end
        ifc.out_ready = 1'b0;

        // Bring count to 5, then flush while pushing and popping
        ifc.in_data = 32'h17;
        step();
        ifc.in_data = 32'h18;
        step();
        chk("pre_flush_count", {28'b0, ifc.count}, 32'd5);
        ifc.in_data   = 32'h99;
        ifc.out_ready = 1'b1;
        flush         = 1'b1;
        step();
        flush         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        chk("flush_count", {28'b0, ifc.count}, 32'd0);
        chk("flush_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("flush_in_ready", {31'b0, ifc.in_ready}, 32'd1);
`ifdef LEAF_FIFO_STATS_EN
        chk("flush_stat_push", {16'b0, stat_push_cnt}, 32'd0);
`endif
        ifc.in_valid = 1'b1;
        ifc.in_data  = 32'h42;
        step();
        chk("post_flush_head", ifc.out_data, 32'h42);
        chk("post_flush_count", {28'b0, ifc.count}, 32'd1);

        // Three more words to reach 4, then asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            ifc.in_data = 32'h50 + i;
            step();
        end
        ifc.in_valid = 1'b0;
        chk("pre_rst_count", {28'b0, ifc.count}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("arst_count", {28'b0, ifc.count}, 32'd0);
        chk("arst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("arst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
        chk("arst_afull", {31'b0, ifc.almost_full}, 32'd0);
        chk("arst_out_data", ifc.out_data, 32'h0);
`ifdef LEAF_FIFO_STATS_EN
        chk("arst_stat_push", {16'b0, stat_push_cnt}, 32'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_count", {28'b0, ifc.count}, 32'd0);
        chk("post_rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
